// File: rtl/decode_pkg.sv
// Shared decode types: immediate-select encoding, opcode constants and the
// per-instruction decoded-field bundle carried alongside each held entry.
package decode_pkg;

  // Immediate-type select consumed by immGen.
  typedef enum logic [2:0] {
    IMM_U    = 3'b000,
    IMM_J    = 3'b001,
    IMM_I    = 3'b010,
    IMM_B    = 3'b011,
    IMM_S    = 3'b100,
    IMM_NONE = 3'b111
  } imm_type_e;

  // Major opcodes (inst[6:0]).
  localparam logic [6:0] OPC_LUI       = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
  localparam logic [6:0] OPC_JAL       = 7'b1101111;
  localparam logic [6:0] OPC_JALR      = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
  localparam logic [6:0] OPC_LOAD      = 7'b0000011;
  localparam logic [6:0] OPC_STORE     = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
  localparam logic [6:0] OPC_OP        = 7'b0110011;
  localparam logic [6:0] OPC_OP_32     = 7'b0111011;
  localparam logic [6:0] OPC_MISC_MEM  = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;

  // Decoded fields stored with every held instruction.
  typedef struct packed {
    imm_type_e  imm_type;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
    logic       uses_rs1;
    logic       uses_rs2;
    logic       writes_rd;
    logic       illegal;
  } decoded_t;

  // Value of the decoded fields while nothing has been captured since reset.
  localparam decoded_t DECODED_RESET = '{
    imm_type:  IMM_NONE,
    rs1:       5'd0,
    rs2:       5'd0,
    rd:        5'd0,
    uses_rs1:  1'b0,
    uses_rs2:  1'b0,
    writes_rd: 1'b0,
    illegal:   1'b0
  };

endpackage

// File: rtl/inst_decode_stage_if.sv
// Fetch-side and decode-side bus of the decode stage.
//
// Handshake: a beat transfers on a rising edge where valid and ready are both
// high. A producer holding valid=1 keeps its payload stable until the beat
// transfers; ready never depends combinationally on valid on the same side.
interface inst_decode_stage_if #(
  parameter int XLEN = 64
);
  import decode_pkg::*;

  // fetch -> decode
  logic            in_valid;
  logic            in_ready;
  logic [XLEN-1:0] in_pc;
  logic [31:0]     in_inst;

  // decode -> immGen / register-file read
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_pc;
  logic [31:0]     out_inst;
  imm_type_e       imm_gen_type;
  logic [4:0]      rs1;
  logic [4:0]      rs2;
  logic [4:0]      rd;
  logic            uses_rs1;
  logic            uses_rs2;
  logic            writes_rd;
  logic            illegal;

  // Environment view: drives fetch payload and downstream ready.
  modport master (
    output in_valid, in_pc, in_inst, out_ready,
    input  in_ready, out_valid, out_pc, out_inst, imm_gen_type,
           rs1, rs2, rd, uses_rs1, uses_rs2, writes_rd, illegal
  );

  // Decode stage view.
  modport slave (
    input  in_valid, in_pc, in_inst, out_ready,
    output in_ready, out_valid, out_pc, out_inst, imm_gen_type,
           rs1, rs2, rd, uses_rs1, uses_rs2, writes_rd, illegal
  );

endinterface

// File: rtl/inst_classify.sv
// Purely combinational opcode classifier: raw instruction -> decoded fields.
module inst_classify
  import decode_pkg::*;
(
  input  logic [31:0] inst,
  output decoded_t    dec
);

  logic [6:0] opcode;
  logic       unused_funct;

  assign opcode       = inst[6:0];
  // funct7 bits do not influence classification.
  assign unused_funct = ^inst[31:25];

  // Classify opcode into immediate type and operand/destination usage.
  always_comb begin
    dec           = DECODED_RESET;
    dec.rs1       = inst[19:15];
    dec.rs2       = inst[24:20];
    dec.rd        = inst[11:7];
    if (inst[1:0] != 2'b11) begin
      dec.illegal = 1'b1;
    end else begin
      case (opcode)
        OPC_LUI, OPC_AUIPC: begin
          dec.imm_type  = IMM_U;
          dec.writes_rd = 1'b1;
        end
        OPC_JAL: begin
          dec.imm_type  = IMM_J;
          dec.writes_rd = 1'b1;
        end
        OPC_JALR, OPC_LOAD, OPC_OP_IMM, OPC_OP_IMM_32, OPC_SYSTEM: begin
          dec.imm_type  = IMM_I;
          dec.uses_rs1  = 1'b1;
          dec.writes_rd = 1'b1;
        end
        OPC_MISC_MEM: begin
          dec.imm_type = IMM_I;
        end
        OPC_BRANCH: begin
          dec.imm_type = IMM_B;
          dec.uses_rs1 = 1'b1;
          dec.uses_rs2 = 1'b1;
        end
        OPC_STORE: begin
          dec.imm_type = IMM_S;
          dec.uses_rs1 = 1'b1;
          dec.uses_rs2 = 1'b1;
        end
        OPC_OP, OPC_OP_32: begin
          dec.imm_type  = IMM_NONE;
          dec.uses_rs1  = 1'b1;
          dec.uses_rs2  = 1'b1;
          dec.writes_rd = 1'b1;
        end
        default: begin
          dec.illegal = 1'b1;
        end
      endcase
    end
    // x0 is never a real destination.
    if (dec.rd == 5'd0) begin
      dec.writes_rd = 1'b0;
    end
  end

endmodule

// File: rtl/inst_decode_stage.sv
// Decode pipeline stage: classifies fetched instructions and presents them,
// registered, to immGen and register-file read. A main output register plus
// one skid register keep one instruction per cycle flowing under backpressure
// while in_ready stays a pure register output.
module inst_decode_stage
  import decode_pkg::*;
#(
  parameter int              XLEN         = 64,
  parameter logic [XLEN-1:0] RESET_PC_TAG = '0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 flush,
  inst_decode_stage_if.slave   bus
);

  decoded_t        in_dec;

  logic            main_valid;
  logic [XLEN-1:0] main_pc;
  logic [31:0]     main_inst;
  decoded_t        main_dec;

  logic            skid_valid;
  logic [XLEN-1:0] skid_pc;
  logic [31:0]     skid_inst;
  decoded_t        skid_dec;

  logic            in_fire;
  logic            out_fire;

  // Decode happens on the input side so the skid entry carries its fields too.
  inst_classify u_classify (
    .inst (bus.in_inst),
    .dec  (in_dec)
  );

  assign in_fire  = bus.in_valid & ~skid_valid;
  assign out_fire = main_valid & bus.out_ready;

  // Main/skid occupancy and payload movement; flush beats every transfer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      main_valid <= 1'b0;
      main_pc    <= RESET_PC_TAG;
      main_inst  <= '0;
      main_dec   <= DECODED_RESET;
      skid_valid <= 1'b0;
      skid_pc    <= RESET_PC_TAG;
      skid_inst  <= '0;
      skid_dec   <= DECODED_RESET;
    end else if (flush) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
    end else if (!main_valid || out_fire) begin
      // Main is free this edge: the older skid entry goes first.
      if (skid_valid) begin
        main_valid <= 1'b1;
        main_pc    <= skid_pc;
        main_inst  <= skid_inst;
        main_dec   <= skid_dec;
        skid_valid <= 1'b0;
      end else if (in_fire) begin
        main_valid <= 1'b1;
        main_pc    <= bus.in_pc;
        main_inst  <= bus.in_inst;
        main_dec   <= in_dec;
      end else begin
        main_valid <= 1'b0;
      end
    end else if (in_fire) begin
      // Main is stalled: park the accepted input in the skid register.
      skid_valid <= 1'b1;
      skid_pc    <= bus.in_pc;
      skid_inst  <= bus.in_inst;
      skid_dec   <= in_dec;
    end
  end

  assign bus.in_ready     = ~skid_valid;
  assign bus.out_valid    = main_valid;
  assign bus.out_pc       = main_pc;
  assign bus.out_inst     = main_inst;
  assign bus.imm_gen_type = main_dec.imm_type;
  assign bus.rs1          = main_dec.rs1;
  assign bus.rs2          = main_dec.rs2;
  assign bus.rd           = main_dec.rd;
  assign bus.uses_rs1     = main_dec.uses_rs1;
  assign bus.uses_rs2     = main_dec.uses_rs2;
  assign bus.writes_rd    = main_dec.writes_rd;
  assign bus.illegal      = main_dec.illegal;

endmodule

// File: tb/tb_inst_decode_stage.sv
// Directed bench for inst_decode_stage. Inputs change and outputs are sampled
// just after the falling edge; the DUT acts on the rising edge.
module tb_inst_decode_stage;
  import decode_pkg::*;

  localparam logic [31:0] ADDI_X1 = 32'h00500093;
  localparam logic [31:0] AUIPC   = 32'h00000297;
  localparam logic [31:0] SW      = 32'h00112223;
  localparam logic [31:0] JAL_X0  = 32'h0000006f;
  localparam logic [31:0] JALR_X0 = 32'h00008067;
  localparam logic [31:0] BEQ     = 32'hfe000ee3;
  localparam logic [31:0] LUI_X1  = 32'h123450b7;
  localparam logic [31:0] ADDI_X2 = 32'h00a00113;
  localparam logic [31:0] ADD_X3  = 32'h002081b3;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic flush = 1'b0;

  int n_checks = 0;
  int n_fail = 0;
  logic [31:0] exp_q[$];

  inst_decode_stage_if #(.XLEN(64)) bus ();

  inst_decode_stage #(
    .XLEN         (64),
    .RESET_PC_TAG (64'h0)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .flush (flush),
    .bus   (bus.slave)
  );

  // Clock
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_dec(input string tag, input logic [2:0] t,
                           input logic [4:0] e_rs1, input logic [4:0] e_rs2,
                           input logic [4:0] e_rd, input logic u1, input logic u2,
                           input logic w, input logic ill);
    check({tag, ".valid"}, bus.out_valid, 1'b1);
    check({tag, ".type"}, bus.imm_gen_type, t);
    check({tag, ".rs1"}, bus.rs1, e_rs1);
    check({tag, ".rs2"}, bus.rs2, e_rs2);
    check({tag, ".rd"}, bus.rd, e_rd);
    check({tag, ".uses_rs1"}, bus.uses_rs1, u1);
    check({tag, ".uses_rs2"}, bus.uses_rs2, u2);
    check({tag, ".writes_rd"}, bus.writes_rd, w);
    check({tag, ".illegal"}, bus.illegal, ill);
  endtask

  task automatic drive(input logic v, input logic [63:0] pc, input logic [31:0] inst);
    bus.in_valid = v;
    bus.in_pc    = pc;
    bus.in_inst  = inst;
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  initial begin
    drive(1'b0, 64'h0, 32'h0);
    bus.out_ready = 1'b0;

    // Reset state while reset is held
    tick();
    tick();
    check("rst.out_valid", bus.out_valid, 1'b0);
    check("rst.type", bus.imm_gen_type, 3'b111);
    check("rst.out_pc", bus.out_pc, 64'h0);
    check("rst.out_inst", bus.out_inst, 32'h0);
    check("rst.writes_rd", bus.writes_rd, 1'b0);
    reset = 1'b0;
    tick();
    check("post_rst.in_ready", bus.in_ready, 1'b1);
    check("post_rst.out_valid", bus.out_valid, 1'b0);

    // Single addi
    bus.out_ready = 1'b1;
    drive(1'b1, 64'h1000, ADDI_X1);
    tick();
    check_dec("addi", 3'b010, 5'd0, 5'd5, 5'd1, 1'b1, 1'b0, 1'b1, 1'b0);
    check("addi.pc", bus.out_pc, 64'h1000);
    check("addi.inst", bus.out_inst, ADDI_X1);
    drive(1'b0, 64'h0, 32'h0);
    tick();
    check("addi.drained", bus.out_valid, 1'b0);

    // Back-to-back auipc then sw
    drive(1'b1, 64'h2000, AUIPC);
    tick();
    check_dec("auipc", 3'b000, 5'd0, 5'd0, 5'd5, 1'b0, 1'b0, 1'b1, 1'b0);
    check("auipc.pc", bus.out_pc, 64'h2000);
    drive(1'b1, 64'h2004, SW);
    tick();
    check_dec("sw", 3'b100, 5'd2, 5'd1, 5'd4, 1'b1, 1'b1, 1'b0, 1'b0);
    check("sw.pc", bus.out_pc, 64'h2004);
    drive(1'b0, 64'h0, 32'h0);
    tick();
    check("sw.drained", bus.out_valid, 1'b0);

    // Stream under backpressure: skid fills, then drains in order
    bus.out_ready = 1'b0;
    drive(1'b1, 64'h4000, ADDI_X1);
    exp_q.push_back(ADDI_X1);
    tick();
    check("stall.i0", bus.out_inst, exp_q[0]);
    check("stall.ready0", bus.in_ready, 1'b1);
    drive(1'b1, 64'h4004, AUIPC);
    exp_q.push_back(AUIPC);
    tick();
    check("stall.ready1", bus.in_ready, 1'b0);
    check("stall.hold1", bus.out_inst, exp_q[0]);
    check("stall.hold1_pc", bus.out_pc, 64'h4000);
    drive(1'b1, 64'h4008, JAL_X0);
    tick();
    check("stall.ready2", bus.in_ready, 1'b0);
    check("stall.hold2", bus.out_inst, exp_q[0]);
    check("stall.hold2_valid", bus.out_valid, 1'b1);
    bus.out_ready = 1'b1;
    tick();
    void'(exp_q.pop_front());
    check("stall.i1", bus.out_inst, exp_q[0]);
    check("stall.i1_pc", bus.out_pc, 64'h4004);
    check("stall.ready3", bus.in_ready, 1'b1);
    exp_q.push_back(JAL_X0);
    tick();
    void'(exp_q.pop_front());
    check("stall.i2", bus.out_inst, exp_q[0]);
    check_dec("jal_x0", 3'b001, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 64'h400c, JALR_X0);
    exp_q.push_back(JALR_X0);
    tick();
    void'(exp_q.pop_front());
    check("stall.i3", bus.out_inst, exp_q[0]);
    check_dec("jalr_x0", 3'b010, 5'd1, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 64'h0, 32'h0);
    tick();
    void'(exp_q.pop_front());
    check("stall.drained", bus.out_valid, 1'b0);
    check("stall.queue_empty", exp_q.size(), 0);

    // Flush with main and skid full
    bus.out_ready = 1'b0;
    drive(1'b1, 64'h3000, BEQ);
    tick();
    check_dec("beq", 3'b011, 5'd0, 5'd0, 5'd29, 1'b1, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 64'h3004, LUI_X1);
    tick();
    check("flush1.full", bus.in_ready, 1'b0);
    drive(1'b1, 64'h3008, ADDI_X2);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    drive(1'b0, 64'h0, 32'h0);
    check("flush1.out_valid", bus.out_valid, 1'b0);
    check("flush1.in_ready", bus.in_ready, 1'b1);
    bus.out_ready = 1'b1;
    tick();
    check("flush1.no_ghost", bus.out_valid, 1'b0);

    // Flush drops a same-cycle accepted input
    bus.out_ready = 1'b0;
    drive(1'b1, 64'h3100, AUIPC);
    tick();
    check("flush2.main", bus.out_inst, AUIPC);
    check("flush2.ready", bus.in_ready, 1'b1);
    drive(1'b1, 64'h3104, SW);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    drive(1'b0, 64'h0, 32'h0);
    check("flush2.out_valid", bus.out_valid, 1'b0);
    check("flush2.in_ready", bus.in_ready, 1'b1);
    bus.out_ready = 1'b1;
    tick();
    check("flush2.no_ghost", bus.out_valid, 1'b0);

    // Illegal encodings and a register-register op
    drive(1'b1, 64'h5000, 32'hffffffff);
    tick();
    check_dec("ill_ones", 3'b111, 5'd31, 5'd31, 5'd31, 1'b0, 1'b0, 1'b0, 1'b1);
    drive(1'b1, 64'h5004, 32'h00000010);
    tick();
    check_dec("ill_low00", 3'b111, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    drive(1'b1, 64'h5008, ADD_X3);
    tick();
    check_dec("add", 3'b111, 5'd1, 5'd2, 5'd3, 1'b1, 1'b1, 1'b1, 1'b0);
    drive(1'b0, 64'h0, 32'h0);
    tick();

    // Asynchronous reset with two entries held
    bus.out_ready = 1'b0;
    drive(1'b1, 64'h6000, ADDI_X1);
    tick();
    drive(1'b1, 64'h6004, SW);
    tick();
    check("areset.full", bus.in_ready, 1'b0);
    drive(1'b0, 64'h0, 32'h0);
    #2 reset = 1'b1;
    #1;
    check("areset.out_valid", bus.out_valid, 1'b0);
    check("areset.type", bus.imm_gen_type, 3'b111);
    check("areset.out_pc", bus.out_pc, 64'h0);
    check("areset.out_inst", bus.out_inst, 32'h0);
    check("areset.in_ready", bus.in_ready, 1'b1);
    tick();
    reset = 1'b0;
    tick();
    check("areset.release_ready", bus.in_ready, 1'b1);
    check("areset.release_valid", bus.out_valid, 1'b0);
    bus.out_ready = 1'b1;
    drive(1'b1, 64'h7000, ADDI_X1);
    tick();
    check_dec("addi_after_rst", 3'b010, 5'd0, 5'd5, 5'd1, 1'b1, 1'b0, 1'b1, 1'b0);
    check("addi_after_rst.pc", bus.out_pc, 64'h7000);
    drive(1'b0, 64'h0, 32'h0);
    tick();
    check("final.drained", bus.out_valid, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/inst_decode_stage.md
Name: inst_decode_stage

Overview:
Decode pipeline stage between instruction fetch and the immediate generator / register-file read. It accepts fetched {pc, inst} over a valid/ready handshake. It classifies the opcode and produces the 3-bit immediate-type select consumed by immGen, along with register indices, usage flags and an illegal flag, all registered. A 2-entry skid buffer sustains one instruction per cycle under backpressure, and a synchronous flush squashes in-flight instructions on redirect.

Parameters:
XLEN, 64, width of pc path
RESET_PC_TAG, 0, value driven on out_pc while out_valid=0 after reset

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
flush  input  1  squash all held instructions (branch/trap redirect)
in_valid  input  1  fetch presents an instruction
in_ready  output  1  stage can accept this cycle
in_pc  input  XLEN  pc of presented instruction
in_inst  input  32  raw instruction word
out_valid  output  1  decoded instruction available
out_ready  input  1  downstream accepts
out_pc  output  XLEN  registered pc
out_inst  output  32  registered instruction (feeds immGen inst)
imm_gen_type  output  3  immGen select: 000 U, 001 J, 010 I, 011 B, 100 S, 111 none
rs1, rs2, rd  output  5 each  inst[19:15], inst[24:20], inst[11:7]
uses_rs1, uses_rs2, writes_rd  output  1 each  operand/destination usage
illegal  output  1  unsupported opcode or inst[1:0]!=2'b11

Behaviour:
- Reset (async assert, sync-release use): out_valid=0, skid empty; all data outputs 0 (out_pc=RESET_PC_TAG, imm_gen_type=111); in_ready=1 from the first cycle after reset deasserts. No capture while reset is high.
- Latency: 1 cycle from accepted input (in_valid&in_ready at edge) to out_valid. Throughput: 1 per cycle while out_ready=1.
- Storage: output register (main) + one skid register. in_ready = !skid_valid (registered, no combinational path from out_ready).
- Transfer rules per edge: out_fire=out_valid&out_ready; in_fire=in_valid&in_ready.
  - Main empty or out_fire: main loads skid if skid_valid (skid clears), else loads input if in_fire.
  - Main full and !out_fire and in_fire: input goes to skid.
  - Simultaneous out_fire and in_fire with skid full: impossible (in_ready=0).
- Outputs stay stable while out_valid=1 and out_ready=0.
- Decode is computed on the input side and stored with each entry (skid holds decoded fields too).
- Decode by inst[6:0]:
  - LUI 0110111, AUIPC 0010111 -> U; writes_rd.
  - JAL 1101111 -> J; writes_rd.
  - JALR 1100111, LOAD 0000011, OP-IMM 0010011, OP-IMM-32 0011011 -> I; uses_rs1, writes_rd.
  - MISC-MEM 0001111 -> I; no flags.
  - SYSTEM 1110011 -> I; uses_rs1, writes_rd.
  - BRANCH 1100011 -> B; uses_rs1, uses_rs2.
  - STORE 0100011 -> S; uses_rs1, uses_rs2.
  - OP 0110011, OP-32 0111011 -> 111; uses_rs1, uses_rs2, writes_rd.
  - Anything else, or inst[1:0]!=11 -> illegal=1, imm_gen_type=111, all flags 0.
- writes_rd forced 0 when rd==0. rs1/rs2/rd are always raw fields.
- Flush: at the edge, main and skid valid clear and any same-cycle in_fire is dropped. The next cycle has out_valid=0 and in_ready=1. Flush has priority over all transfers.
- Reset mid-operation: all held instructions are discarded immediately (async).

Decomposition:
- Shared package decode_pkg: imm_type_e enum (IMM_U=000, IMM_J=001, IMM_I=010, IMM_B=011, IMM_S=100, IMM_NONE=111), opcode constants, and a decoded-fields struct (imm type, rs1/rs2/rd, flags, illegal).
- immGen switches to imm_type_e, which also fixes the I-type select encoding to 3'b010.
- Sub-module inst_classify: purely combinational inst -> struct. The stage instantiates it once on the input side.

Test Plan:
- 0x00500093 (addi x1,x0,5), out_ready=1 -> next cycle out_valid=1, imm_gen_type=010, rs1=0, rd=1, uses_rs1=1, writes_rd=1, illegal=0.
- Back-to-back 0x00000297 (auipc x5) then 0x00112223 (sw x1,4(x2)), out_ready=1 -> consecutive cycles give type 000/rd=5/writes_rd=1, then type 100/rs1=2/rs2=1/writes_rd=0.
- Stream 4 instrs, out_ready=0 for 3 cycles -> in_ready drops after 2 accepted; out fields stable; on release, all 4 emerge in order, none lost or duplicated.
- 0xfe000ee3 (beq) in main + skid full, flush=1 with in_valid=1 -> next cycle out_valid=0, in_ready=1; the flushed-cycle input never appears.
- 0xFFFFFFFF and 0x00000013 with inst[1:0] forced to 00 -> illegal=1, imm_gen_type=111, all flags 0.
- Assert reset asynchronously while 2 entries are held -> out_valid=0 and imm_gen_type=111 immediately; after release, in_ready=1 and a new addi decodes normally.
